// File: rtl/accel_pkg.sv
// Shared encodings for the accelerator sequencer: instruction field layout,
// opcodes, FSM states and the default array size.
package accel_pkg;

  localparam int ARR_SIZE_DEF = 4;

  localparam int OP_LSB    = 60;
  localparam int OP_W      = 4;
  localparam int ADDR_LSB  = 45;
  localparam int ADDR_W    = 15;
  localparam int CLR_BIT   = 44;
  localparam int OADDR_LSB = 40;
  localparam int OADDR_W   = 4;
  localparam int LEN_LSB   = 32;
  localparam int LEN_W     = 8;
  localparam int DATA_LSB  = 0;
  localparam int DATA_W    = 32;

  localparam logic [OP_W-1:0] OP_NOP     = 4'd0;
  localparam logic [OP_W-1:0] OP_LD_INP  = 4'd1;
  localparam logic [OP_W-1:0] OP_LD_WT   = 4'd2;
  localparam logic [OP_W-1:0] OP_COMPUTE = 4'd3;
  localparam logic [OP_W-1:0] OP_STORE   = 4'd4;
  localparam logic [OP_W-1:0] OP_READ    = 4'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FEED,
    ST_FLUSH,
    ST_STORE,
    ST_READ
  } state_e;

  // Opcodes above READ are reserved and rejected with an error pulse.
  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return op <= OP_READ;
  endfunction

endpackage

// File: rtl/seq_addr_gen.sv
// Feed address generator: walks base..base+len-1 (wrapping), then counts
// down the skew flush while holding the final address.
module seq_addr_gen #(
  parameter int AW        = 15,
  parameter int LW        = 8,
  parameter int FLUSH_LEN = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [LW-1:0] len,
  output logic [AW-1:0] addr,
  output logic          last_beat,
  output logic          flush_last
);

  localparam int FW = $clog2(FLUSH_LEN + 1);

  logic [LW-1:0] beat_cnt;
  logic [FW-1:0] flush_cnt;
  logic          feeding;
  logic          flushing;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
      feeding   <= 1'b0;
      flushing  <= 1'b0;
    end else if (start) begin
      addr      <= base;
      beat_cnt  <= len - LW'(1);
      feeding   <= 1'b1;
      flushing  <= 1'b0;
    end else if (feeding) begin
      if (beat_cnt == '0) begin
        feeding   <= 1'b0;
        flushing  <= 1'b1;
        flush_cnt <= FW'(FLUSH_LEN - 1);
      end else begin
        // Natural overflow of the AW-bit adder gives the modulo-2^AW wrap.
        addr     <= addr + AW'(1);
        beat_cnt <= beat_cnt - LW'(1);
      end
    end else if (flushing) begin
      if (flush_cnt == '0) begin
        flushing <= 1'b0;
      end else begin
        flush_cnt <= flush_cnt - FW'(1);
      end
    end
  end

  assign last_beat  = feeding && (beat_cnt == '0);
  assign flush_last = flushing && (flush_cnt == '0);

endmodule

// File: rtl/systolic_sequencer.sv
// Single-issue sequencer: decodes one instruction at a time and drives the
// buffer write, feed/flush, accumulator store and readback strobes.
module systolic_sequencer
  import accel_pkg::*;
#(
  parameter int ARR_SIZE = ARR_SIZE_DEF,
  parameter int AW       = 15,
  parameter int OAW      = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           instr_valid,
  input  logic [63:0]    instr,
  output logic           instr_ready,
  output logic           inp_buf_we,
  output logic [AW-1:0]  inp_buf_addr,
  output logic [31:0]    inp_buf_data,
  output logic           wt_buf_we,
  output logic [AW-1:0]  wt_buf_addr,
  output logic [31:0]    wt_buf_data,
  output logic           arr_en,
  output logic [AW-1:0]  arr_rd_addr,
  output logic           acc_clear,
  output logic           acc_store,
  output logic [OAW-1:0] acc_op_addr,
  output logic           op_buf_rd_en,
  output logic [OAW-1:0] op_buf_rd_addr,
  output logic           busy,
  output logic           err
);

  localparam int FLUSH_LEN = 2 * ARR_SIZE - 1;

  state_e state;

  logic [OP_W-1:0]   op_in;
  logic [AW-1:0]     addr_in;
  logic              clr_in;
  logic [OAW-1:0]    oaddr_in;
  logic [LEN_W-1:0]  len_in;
  logic [DATA_W-1:0] data_in;
  logic              accept;
  logic              illegal;
  logic              gen_start;
  logic              last_beat;
  logic              flush_last;

  assign op_in    = instr[OP_LSB +: OP_W];
  assign addr_in  = instr[ADDR_LSB +: AW];
  assign clr_in   = instr[CLR_BIT];
  assign oaddr_in = instr[OADDR_LSB +: OAW];
  assign len_in   = instr[LEN_LSB +: LEN_W];
  assign data_in  = instr[DATA_LSB +: DATA_W];

  assign accept    = instr_valid && instr_ready;
  assign illegal   = !op_legal(op_in) || ((op_in == OP_COMPUTE) && (len_in == '0));
  assign gen_start = accept && (op_in == OP_COMPUTE) && (len_in != '0);

  seq_addr_gen #(
    .AW        (AW),
    .LW        (LEN_W),
    .FLUSH_LEN (FLUSH_LEN)
  ) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (gen_start),
    .base       (addr_in),
    .len        (len_in),
    .addr       (arr_rd_addr),
    .last_beat  (last_beat),
    .flush_last (flush_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      instr_ready    <= 1'b1;
      busy           <= 1'b0;
      err            <= 1'b0;
      inp_buf_we     <= 1'b0;
      inp_buf_addr   <= '0;
      inp_buf_data   <= '0;
      wt_buf_we      <= 1'b0;
      wt_buf_addr    <= '0;
      wt_buf_data    <= '0;
      arr_en         <= 1'b0;
      acc_clear      <= 1'b0;
      acc_store      <= 1'b0;
      acc_op_addr    <= '0;
      op_buf_rd_en   <= 1'b0;
      op_buf_rd_addr <= '0;
    end else begin
      // Single-cycle strobes drop unless re-asserted below.
      inp_buf_we   <= 1'b0;
      wt_buf_we    <= 1'b0;
      acc_clear    <= 1'b0;
      acc_store    <= 1'b0;
      op_buf_rd_en <= 1'b0;
      err          <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (illegal) begin
              err <= 1'b1;
            end else begin
              case (op_in)
                OP_LD_INP: begin
                  inp_buf_we   <= 1'b1;
                  inp_buf_addr <= addr_in;
                  inp_buf_data <= data_in;
                  state        <= ST_LOAD;
                  instr_ready  <= 1'b0;
                  busy         <= 1'b1;
                end
                OP_LD_WT: begin
                  wt_buf_we   <= 1'b1;
                  wt_buf_addr <= addr_in;
                  wt_buf_data <= data_in;
                  state       <= ST_LOAD;
                  instr_ready <= 1'b0;
                  busy        <= 1'b1;
                end
                OP_COMPUTE: begin
                  arr_en      <= 1'b1;
                  acc_clear   <= clr_in;
                  state       <= ST_FEED;
                  instr_ready <= 1'b0;
                  busy        <= 1'b1;
                end
                OP_STORE: begin
                  acc_store   <= 1'b1;
                  acc_op_addr <= oaddr_in;
                  state       <= ST_STORE;
                  instr_ready <= 1'b0;
                  busy        <= 1'b1;
                end
                OP_READ: begin
                  op_buf_rd_en   <= 1'b1;
                  op_buf_rd_addr <= oaddr_in;
                  state          <= ST_READ;
                  instr_ready    <= 1'b0;
                  busy           <= 1'b1;
                end
                default: ;
              endcase
            end
          end
        end
        ST_LOAD, ST_STORE, ST_READ: begin
          state       <= ST_IDLE;
          instr_ready <= 1'b1;
          busy        <= 1'b0;
        end
        ST_FEED: begin
          if (last_beat) begin
            state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (flush_last) begin
            arr_en      <= 1'b0;
            state       <= ST_IDLE;
            instr_ready <= 1'b1;
            busy        <= 1'b0;
          end
        end
        default: begin
          arr_en      <= 1'b0;
          state       <= ST_IDLE;
          instr_ready <= 1'b1;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_sequencer.sv
// Bench for systolic_sequencer: per-cycle output snapshots plus a queue of
// expected strobe events that is drained against the snapshots at the end.
module tb_systolic_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [63:0] instr = '0;
  logic        instr_ready;
  logic        inp_buf_we;
  logic [14:0] inp_buf_addr;
  logic [31:0] inp_buf_data;
  logic        wt_buf_we;
  logic [14:0] wt_buf_addr;
  logic [31:0] wt_buf_data;
  logic        arr_en;
  logic [14:0] arr_rd_addr;
  logic        acc_clear;
  logic        acc_store;
  logic [3:0]  acc_op_addr;
  logic        op_buf_rd_en;
  logic [3:0]  op_buf_rd_addr;
  logic        busy;
  logic        err;

  always #5 clk = ~clk;

  systolic_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_ready    (instr_ready),
    .inp_buf_we     (inp_buf_we),
    .inp_buf_addr   (inp_buf_addr),
    .inp_buf_data   (inp_buf_data),
    .wt_buf_we      (wt_buf_we),
    .wt_buf_addr    (wt_buf_addr),
    .wt_buf_data    (wt_buf_data),
    .arr_en         (arr_en),
    .arr_rd_addr    (arr_rd_addr),
    .acc_clear      (acc_clear),
    .acc_store      (acc_store),
    .acc_op_addr    (acc_op_addr),
    .op_buf_rd_en   (op_buf_rd_en),
    .op_buf_rd_addr (op_buf_rd_addr),
    .busy           (busy),
    .err            (err)
  );

  typedef struct packed {
    logic        ready;
    logic        busy;
    logic        err;
    logic        inp_we;
    logic [14:0] inp_addr;
    logic [31:0] inp_data;
    logic        wt_we;
    logic [14:0] wt_addr;
    logic [31:0] wt_data;
    logic        arr_en;
    logic [14:0] arr_addr;
    logic        clear;
    logic        store;
    logic [3:0]  op_addr;
    logic        rd_en;
    logic [3:0]  rd_addr;
  } snap_t;

  // kind: 1 inp write, 2 wt write, 3 acc clear, 4 store, 5 read, 6 err, 7 array beat
  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] a;
    logic [31:0] d;
  } exp_t;

  localparam int NSNAP = 4096;

  snap_t snap [NSNAP];
  exp_t  exp_q [$];
  int    cyc = 0;
  int    vectors = 0;
  int    miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cyc < NSNAP) begin
      snap[cyc] = '{ready: instr_ready, busy: busy, err: err,
                    inp_we: inp_buf_we, inp_addr: inp_buf_addr, inp_data: inp_buf_data,
                    wt_we: wt_buf_we, wt_addr: wt_buf_addr, wt_data: wt_buf_data,
                    arr_en: arr_en, arr_addr: arr_rd_addr, clear: acc_clear,
                    store: acc_store, op_addr: acc_op_addr,
                    rd_en: op_buf_rd_en, rd_addr: op_buf_rd_addr};
    end
  end

  function automatic logic [63:0] mk(input logic [3:0] op, input logic [14:0] a,
                                     input logic clr, input logic [3:0] oa,
                                     input logic [7:0] len, input logic [31:0] d);
    return {op, a, clr, oa, len, d};
  endfunction

  task automatic push(input int c, input int k, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.cyc = c; e.kind = k; e.a = a; e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Holds the word valid until the DUT takes it; returns the accept cycle.
  task automatic send(input logic [63:0] w, output int acc);
    acc = -1;
    instr = w;
    instr_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (snap[cyc].ready === 1'b1) begin
        acc = cyc;
        break;
      end
      tick(1);
    end
    if (acc < 0) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout got=no_accept exp=accept word=%h", w);
    end
    tick(1);
    instr_valid = 1'b0;
  endtask

  task automatic test_reset();
    snap_t e;
    tick(3);
    e = '0;
    e.ready = 1'b1;
    vectors++;
    if (snap[cyc] !== e) begin
      miscompares++;
      $display("FAIL reset_outputs got=%h exp=%h", snap[cyc], e);
    end
    rst_n = 1'b1;
    tick(2);
    vectors++;
    if ({snap[cyc].ready, snap[cyc].busy} !== 2'b10) begin
      miscompares++;
      $display("FAIL reset_release got=%b exp=10", {snap[cyc].ready, snap[cyc].busy});
    end
  endtask

  task automatic test_loads();
    int c;
    logic [14:0] a;
    logic [31:0] d;
    send(mk(4'd1, 15'h0010, 1'b0, 4'd0, 8'd0, 32'hDEADBEEF), c);
    push(c + 1, 1, 32'h0010, 32'hDEADBEEF);
    tick(1);
    vectors++;
    if ({snap[c + 1].ready, snap[c + 2].ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL load_ready got=%b exp=01", {snap[c + 1].ready, snap[c + 2].ready});
    end
    for (int i = 0; i < 6; i++) begin
      a = 15'($urandom);
      d = $urandom;
      send(mk((i % 2 == 0) ? 4'd2 : 4'd1, a, 1'b0, 4'd0, 8'd0, d), c);
      push(c + 1, (i % 2 == 0) ? 2 : 1, {17'd0, a}, d);
    end
    tick(1);
  endtask

  task automatic test_compute();
    int c;
    int n;
    send(mk(4'd3, 15'h7FFE, 1'b1, 4'd0, 8'd4, 32'd0), c);
    push(c + 1, 3, 0, 0);
    for (int i = 0; i < 4; i++) push(c + 1 + i, 7, (32'h7FFE + 32'(i)) & 32'h7FFF, 0);
    for (int j = 0; j < 7; j++) push(c + 5 + j, 7, 32'h0001, 0);
    tick(12);
    n = 0;
    for (int k = c + 1; k <= c + 12; k++) if (snap[k].busy === 1'b1) n++;
    vectors++;
    if (n != 11) begin
      miscompares++;
      $display("FAIL compute_busy_cycles got=%0d exp=11", n);
    end
    vectors++;
    if (snap[c + 12].ready !== 1'b1) begin
      miscompares++;
      $display("FAIL compute_ready_after got=%b exp=1", snap[c + 12].ready);
    end
    send(mk(4'd3, 15'h0100, 1'b0, 4'd0, 8'd2, 32'd0), c);
    for (int i = 0; i < 2; i++) push(c + 1 + i, 7, 32'h0100 + 32'(i), 0);
    for (int j = 0; j < 7; j++) push(c + 3 + j, 7, 32'h0101, 0);
    tick(10);
  endtask

  task automatic test_errors();
    int c1;
    int c2;
    int c3;
    send(mk(4'hA, 15'h0001, 1'b0, 4'd0, 8'd1, 32'd0), c1);
    push(c1 + 1, 6, 0, 0);
    send(mk(4'd3, 15'h0200, 1'b1, 4'd0, 8'd0, 32'd0), c2);
    push(c2 + 1, 6, 0, 0);
    vectors++;
    if (c2 != c1 + 1) begin
      miscompares++;
      $display("FAIL err_ready_stays got=%0d exp=%0d", c2, c1 + 1);
    end
    send(mk(4'd0, 15'h0003, 1'b1, 4'd2, 8'd5, 32'h1234), c3);
    vectors++;
    if ({snap[c1 + 1].ready, snap[c2 + 1].ready, snap[c3 + 1].ready, snap[c3 + 1].busy} !== 4'b1110) begin
      miscompares++;
      $display("FAIL err_nop_ready got=%b exp=1110",
               {snap[c1 + 1].ready, snap[c2 + 1].ready, snap[c3 + 1].ready, snap[c3 + 1].busy});
    end
    tick(1);
  endtask

  task automatic test_back_to_back();
    int c1;
    int c2;
    send(mk(4'd4, 15'h0000, 1'b0, 4'd3, 8'd0, 32'd0), c1);
    send(mk(4'd5, 15'h0000, 1'b0, 4'd3, 8'd0, 32'd0), c2);
    push(c1 + 1, 4, 3, 0);
    push(c2 + 1, 5, 3, 0);
    vectors++;
    if (c2 - c1 != 2) begin
      miscompares++;
      $display("FAIL b2b_spacing got=%0d exp=2", c2 - c1);
    end
    tick(1);
  endtask

  task automatic test_reset_mid_feed();
    int c;
    send(mk(4'd3, 15'h0100, 1'b1, 4'd0, 8'd8, 32'd0), c);
    tick(2);
    push(c + 1, 3, 0, 0);
    for (int i = 0; i < 3; i++) push(c + 1 + i, 7, 32'h0100 + 32'(i), 0);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({inp_buf_we, wt_buf_we, arr_en, acc_clear, acc_store, op_buf_rd_en, err, busy, instr_ready} !== 9'b000000001) begin
      miscompares++;
      $display("FAIL reset_mid_outputs got=%b exp=000000001",
               {inp_buf_we, wt_buf_we, arr_en, acc_clear, acc_store, op_buf_rd_en, err, busy, instr_ready});
    end
    tick(2);
    rst_n = 1'b1;
    tick(2);
    vectors++;
    if ({snap[cyc].ready, snap[cyc].busy} !== 2'b10) begin
      miscompares++;
      $display("FAIL reset_mid_idle got=%b exp=10", {snap[cyc].ready, snap[cyc].busy});
    end
    send(mk(4'd1, 15'h0042, 1'b0, 4'd0, 8'd0, 32'hCAFEF00D), c);
    push(c + 1, 1, 32'h0042, 32'hCAFEF00D);
    tick(1);
  endtask

  task automatic test_hold_during_compute();
    int c;
    int c2;
    send(mk(4'd3, 15'h0020, 1'b0, 4'd0, 8'd3, 32'd0), c);
    send(mk(4'd2, 15'h0055, 1'b0, 4'd0, 8'd0, 32'h0BADF00D), c2);
    for (int i = 0; i < 3; i++) push(c + 1 + i, 7, 32'h0020 + 32'(i), 0);
    for (int j = 0; j < 7; j++) push(c + 4 + j, 7, 32'h0022, 0);
    push(c2 + 1, 2, 32'h0055, 32'h0BADF00D);
    vectors++;
    if (c2 != c + 11) begin
      miscompares++;
      $display("FAIL hold_accept_cycle got=%0d exp=%0d", c2 - c, 11);
    end
    tick(1);
  endtask

  task automatic test_scoreboard();
    int n;
    exp_t e;
    snap_t s;
    logic [64:0] obs;
    tick(3);
    n = 0;
    for (int k = 1; k <= cyc && k < NSNAP; k++) begin
      n += int'(snap[k].inp_we === 1'b1) + int'(snap[k].wt_we === 1'b1)
         + int'(snap[k].clear === 1'b1) + int'(snap[k].store === 1'b1)
         + int'(snap[k].rd_en === 1'b1) + int'(snap[k].err === 1'b1)
         + int'(snap[k].arr_en === 1'b1);
    end
    vectors++;
    if (n != exp_q.size()) begin
      miscompares++;
      $display("FAIL strobe_count got=%0d exp=%0d", n, exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      s = snap[e.cyc];
      case (e.kind)
        1:       obs = {s.inp_we, 17'd0, s.inp_addr, s.inp_data};
        2:       obs = {s.wt_we, 17'd0, s.wt_addr, s.wt_data};
        3:       obs = {s.clear, 64'd0};
        4:       obs = {s.store, 28'd0, s.op_addr, 32'd0};
        5:       obs = {s.rd_en, 28'd0, s.rd_addr, 32'd0};
        6:       obs = {s.err, 64'd0};
        default: obs = {s.arr_en, 17'd0, s.arr_addr, 32'd0};
      endcase
      vectors++;
      if (obs !== {1'b1, e.a, e.d}) begin
        miscompares++;
        $display("FAIL event_kind%0d cyc=%0d got=%h exp=%h", e.kind, e.cyc, obs, {1'b1, e.a, e.d});
      end
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_compute();
    test_errors();
    test_back_to_back();
    test_reset_mid_feed();
    test_hold_during_compute();
    test_scoreboard();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
